uart_tx_cfg: RTL

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. It supports configurable data width, parity mode and stop-bit count, with a send/busy handshake and a one-cycle completion pulse. An optional transmit FIFO can be compiled in. It sits between the host-side byte producer and the serial tx pin.

---
 rtl/uart_tx_cfg.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg - parametrised UART transmitter
//
// Sends DATA_BITS of payload LSB first, framed by one start bit, an optional
// parity bit and STOP_BITS stop bits. Every bit lasts CLK_FREQ/BAUD_RATE
// clock cycles.
//
// Build option:
//   UART_TX_FIFO_EN - when defined, send/data push into a FIFO_DEPTH-entry
//                     queue. The FSM drains the queue one frame at a time and
//                     busy reports "queue full". When undefined, send is only
//                     accepted while idle and busy reports "frame in progress".
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous reset, active low
//   send    - transmit request, sampled on the rising edge
//   data    - payload, DATA_BITS wide, sent LSB first
//   tx      - registered serial output, idle high
//   busy    - frame in progress (no FIFO) / FIFO full (FIFO build)
//   tx_done - one-cycle pulse when the last stop bit of a frame completes
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W        = $clog2(DATA_BITS);
    localparam logic PAR_ODD    = (PARITY == 1);

    // Parameter legality
    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [BIT_W-1:0]     bit_reg, bit_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 par_reg, par_next;
    logic                 tx_reg, tx_next;
    logic                 done_reg, done_next;
    logic                 wrap;

    // Frame source: either the input port directly or the FIFO head
    logic                 start_frame;
    logic [DATA_BITS-1:0] load_data;

`ifdef UART_TX_FIFO_EN
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count_reg == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign push       = send && !fifo_full;
    assign pop        = start_frame;

    // The head entry is read straight into the shift register on the pop
    // edge, so the frame starts on the edge that ends the IDLE cycle.
    assign start_frame = (state_reg == S_IDLE) && !fifo_empty;
    assign load_data   = fifo_mem[rd_ptr_reg];
    assign busy        = fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
`else
    logic busy_reg;

    assign start_frame = (state_reg == S_IDLE) && send && !busy_reg;
    assign load_data   = data;
    assign busy        = busy_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_reg <= 1'b0;
        end else begin
            busy_reg <= (state_next != S_IDLE);
        end
    end
`endif

    assign wrap = (cnt_reg == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state logic. tx_next is derived from the *next* state so that the
    // registered tx already shows the new bit on the edge the state changes.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        par_next   = par_reg;
        done_next  = 1'b0;

        if (state_reg != S_IDLE) begin
            cnt_next = wrap ? '0 : cnt_reg + 1'b1;
        end

        case (state_reg)
            S_IDLE: begin
                if (start_frame) begin
                    state_next = S_START;
                    cnt_next   = '0;
                    bit_next   = '0;
                    shift_next = load_data;
                    par_next   = (^load_data) ^ PAR_ODD;
                end
            end
            S_START: begin
                if (wrap) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (wrap) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (wrap) begin
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (wrap) begin
                    if (bit_reg == BIT_W'(STOP_BITS - 1)) begin
                        bit_next   = '0;
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                bit_next   = '0;
            end
        endcase

        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shift_next[0];
            S_PARITY: tx_next = par_next;
            default:  tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            tx_reg    <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            par_reg   <= par_next;
            tx_reg    <= tx_next;
            done_reg  <= done_next;
        end
    end

    assign tx      = tx_reg;
    assign tx_done = done_reg;

endmodule
